// File: rtl/uart_rx_oversampler_if.sv
// Receive-side bus for uart_rx_oversampler: line input, enable, and the
// received byte with its status flags. The DUT uses the slave modport, the
// host/bench side uses the master modport.
interface uart_rx_oversampler_if;
    logic       rx_en;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx_en,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx_en,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receiver with 16x oversampling: synchronizes rx_in, detects the start
// edge, samples each bit at its centre and checks the stop bit. 8N1 by
// default; defining RX_PARITY_EN adds an even-parity bit (8E1) and drives
// parity_err.
module uart_rx_oversampler #(
    parameter int rx_sys_clk = 50000000,
    parameter int baud_rate  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_oversampler_if.slave bus
);
    localparam int DIV   = rx_sys_clk / (baud_rate * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             rxs_prev_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;
    logic [3:0]       samp_cnt_q;
    logic [3:0]       samp_cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             busy_q;
    logic             ferr_q;
`ifdef RX_PARITY_EN
    logic             par_q;
    logic             perr_q;
`endif
    logic             rxs;
    logic             start_edge;
    logic             tick;

    assign rxs        = sync2_q;
    assign start_edge = rxs_prev_q & ~rxs;
    // One tick per DIV clocks, only while a frame is in progress.
    assign tick       = bus.rx_en && (state_q != IDLE) && (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign samp_cnt_d = samp_cnt_q + 4'd1;

    // Two-stage synchronizer for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= bus.rx_in;
            sync2_q    <= sync1_q;
            rxs_prev_q <= sync2_q;
        end
    end

    // Frame FSM: tick/sample counting, bit capture and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (!bus.rx_en) begin
                // Disable aborts the frame; delivered data and flags are kept.
                state_q    <= IDLE;
                tick_cnt_q <= '0;
                samp_cnt_q <= '0;
                bit_idx_q  <= '0;
                busy_q     <= 1'b0;
            end else if (state_q == IDLE) begin
                tick_cnt_q <= '0;
                samp_cnt_q <= '0;
                bit_idx_q  <= '0;
                if (start_edge) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                end
            end else begin
                tick_cnt_q <= tick_cnt_d;
                if (tick) begin
                    samp_cnt_q <= samp_cnt_d;
                    case (state_q)
                        START: begin
                            // Half a bit in: confirm the start bit is still low.
                            if (samp_cnt_q == MID_SAMPLE) begin
                                samp_cnt_q <= '0;
                                if (!rxs) begin
                                    state_q <= DATA;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                        DATA: begin
                            if (samp_cnt_q == LAST_SAMPLE) begin
                                samp_cnt_q         <= '0;
                                shift_q[bit_idx_q] <= rxs;
                                bit_idx_q          <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                                    state_q <= PARITY;
`else
                                    state_q <= STOP;
`endif
                                end
                            end
                        end
`ifdef RX_PARITY_EN
                        PARITY: begin
                            if (samp_cnt_q == LAST_SAMPLE) begin
                                samp_cnt_q <= '0;
                                par_q      <= rxs;
                                state_q    <= STOP;
                            end
                        end
`endif
                        STOP: begin
                            // Byte is delivered even when the stop bit is bad.
                            if (samp_cnt_q == LAST_SAMPLE) begin
                                samp_cnt_q <= '0;
                                data_q     <= shift_q;
                                valid_q    <= 1'b1;
                                ferr_q     <= ~rxs;
`ifdef RX_PARITY_EN
                                perr_q     <= (^shift_q) ^ par_q;
`endif
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy_q;
    assign bus.frame_err = ferr_q;
`ifdef RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: randomized and directed serial frames, with
// expected bytes/flags computed from the frame contents. Honours RX_PARITY_EN.
module tb_uart_rx_oversampler;
    localparam int SYS_CLK = 1600000;
    localparam int BAUD    = 10000;
    localparam int BIT     = 160;   // clocks per bit (DIV=10, 16 ticks)
`ifdef RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif
    localparam int NBITS   = PAR_EN ? 11 : 10;
    // start edge to rx_valid: (frame bits - 0.5) bit times plus synchronizer delay
    localparam int LAT_MIN = (NBITS * 16 - 8) * 10 + 1;
    localparam int LAT_MAX = (NBITS * 16 - 8) * 10 + 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_oversampler_if bus();

    uart_rx_oversampler #(
        .rx_sys_clk(SYS_CLK),
        .baud_rate (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       busy;
        logic       busy_prev;
        int         cyc;
    } obs_t;

    obs_t       obs_q[$];
    obs_t       mon_o;
    int         cyc = 0;
    int         wide_cnt = 0;
    logic       prev_v = 1'b0;
    logic       prev_busy = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rx_valid pulse with the flags and busy around it.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            mon_o.d         = bus.rx_data;
            mon_o.fe        = bus.frame_err;
            mon_o.pe        = bus.parity_err;
            mon_o.busy      = bus.rx_busy;
            mon_o.busy_prev = prev_busy;
            mon_o.cyc       = cyc;
            obs_q.push_back(mon_o);
            if (prev_v === 1'b1) wide_cnt++;
        end
        prev_v    = bus.rx_valid;
        prev_busy = bus.rx_busy;
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic stop, input logic par);
        if (PAR_EN) return {stop, par, d, 1'b0};
        else        return {1'b0, stop, d, 1'b0};
    endfunction

    function automatic logic exp_pe(input logic [7:0] d, input logic par);
        return PAR_EN ? ((^d) ^ par) : 1'b0;
    endfunction

    // Called at a negedge; holds rx_in for one bit time.
    task automatic drive_bit(input logic b);
        bus.rx_in = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        logic [10:0] f;
        f = mk_frame(d, stop, par);
        for (int i = 0; i < NBITS; i++) drive_bit(f[i]);
    endtask

    task automatic test_reset();
        bus.rx_in = 1'b1;
        bus.rx_en = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_por: got %h want 000", {bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        total++;
        if (bus.rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_mid: got %b want 1", bus.rx_busy);
        end
        bus.rx_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid: got %h want 000", {bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err});
        end
        rst = 1'b1;
        repeat (NBITS * BIT + 50) @(negedge clk);
        total++;
        if (obs_q.size() != 0 || bus.rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: pulses=%0d busy=%b want 0 0", obs_q.size(), bus.rx_busy);
        end
    endtask

    task automatic test_basic();
        int n0;
        int t0;
        n0 = obs_q.size();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        repeat (40) @(negedge clk);
        last_data = 8'hA5;
        total++;
        if (obs_q.size() != n0 + 1) begin
            bad++;
            $display("FAIL basic_count: got %0d want %0d", obs_q.size(), n0 + 1);
        end else begin
            total++;
            if ({obs_q[n0].d, obs_q[n0].fe, obs_q[n0].pe} !== {8'hA5, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL basic_data: got %h/%b/%b want a5/0/0", obs_q[n0].d, obs_q[n0].fe, obs_q[n0].pe);
            end
            total++;
            if ({obs_q[n0].busy_prev, obs_q[n0].busy} !== 2'b10) begin
                bad++;
                $display("FAIL basic_busy_edge: got %b want 10", {obs_q[n0].busy_prev, obs_q[n0].busy});
            end
            total++;
            if (obs_q[n0].cyc - t0 < LAT_MIN || obs_q[n0].cyc - t0 > LAT_MAX) begin
                bad++;
                $display("FAIL basic_latency: got %0d want %0d..%0d", obs_q[n0].cyc - t0, LAT_MIN, LAT_MAX);
            end
        end
        total++;
        if (wide_cnt != 0) begin
            bad++;
            $display("FAIL valid_width: got %0d wide pulses want 0", wide_cnt);
        end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = obs_q.size();
        bus.rx_in = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (bus.rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy_on: got %b want 1", bus.rx_busy);
        end
        repeat (28) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if (obs_q.size() != n0 || bus.rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_reject: pulses=%0d busy=%b want %0d 0", obs_q.size(), bus.rx_busy, n0);
        end
    endtask

    task automatic test_frame_err();
        int n0;
        n0 = obs_q.size();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        bus.rx_in = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h00, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        last_data = 8'h00;
        total++;
        if (obs_q.size() != n0 + 2) begin
            bad++;
            $display("FAIL ferr_count: got %0d want %0d", obs_q.size(), n0 + 2);
        end else begin
            total++;
            if ({obs_q[n0].d, obs_q[n0].fe} !== {8'h3C, 1'b1}) begin
                bad++;
                $display("FAIL ferr_bad_stop: got %h/%b want 3c/1", obs_q[n0].d, obs_q[n0].fe);
            end
            total++;
            if ({obs_q[n0+1].d, obs_q[n0+1].fe} !== {8'h00, 1'b0}) begin
                bad++;
                $display("FAIL ferr_clear: got %h/%b want 00/0", obs_q[n0+1].d, obs_q[n0+1].fe);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = obs_q.size();
        send_frame(8'h55, 1'b1, ^8'h55);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        repeat (40) @(negedge clk);
        last_data = 8'hFF;
        total++;
        if (obs_q.size() != n0 + 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), n0 + 2);
        end else begin
            total++;
            if ({obs_q[n0].d, obs_q[n0+1].d} !== {8'h55, 8'hFF}) begin
                bad++;
                $display("FAIL b2b_data: got %h %h want 55 ff", obs_q[n0].d, obs_q[n0+1].d);
            end
        end
    endtask

    task automatic test_abort();
        int n0;
        logic [7:0] d;
        d = 8'h81;
        n0 = obs_q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        bus.rx_in = d[4];
        repeat (BIT / 2) @(negedge clk);
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: got %b want 0", bus.rx_busy);
        end
        repeat (BIT / 2 - 2) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(^d);
        drive_bit(1'b1);
        // Whole frame while disabled must be ignored.
        send_frame(8'h3C, 1'b1, ^8'h3C);
        repeat (20) @(negedge clk);
        total++;
        if (obs_q.size() != n0 || bus.rx_data !== last_data || bus.rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold: pulses=%0d data=%h busy=%b want %0d %h 0", obs_q.size(), bus.rx_data, bus.rx_busy, n0, last_data);
        end
        bus.rx_en = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(d, 1'b1, ^d);
        repeat (40) @(negedge clk);
        last_data = d;
        total++;
        if (obs_q.size() != n0 + 1 || bus.rx_data !== 8'h81) begin
            bad++;
            $display("FAIL abort_recover: pulses=%0d data=%h want %0d 81", obs_q.size(), bus.rx_data, n0 + 1);
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        int n0;
        n0 = obs_q.size();
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        last_data = 8'h07;
        total++;
        if (obs_q.size() != n0 + 2) begin
            bad++;
            $display("FAIL parity_count: got %0d want %0d", obs_q.size(), n0 + 2);
        end else begin
            total++;
            if ({obs_q[n0].pe, obs_q[n0+1].pe} !== 2'b10) begin
                bad++;
                $display("FAIL parity_flag: got %b%b want 10", obs_q[n0].pe, obs_q[n0+1].pe);
            end
        end
    endtask
`endif

    task automatic test_random();
        obs_t exp_q[$];
        obs_t e;
        int   n0;
        int   gap;
        logic [7:0] d;
        logic stop;
        logic par;
        n0 = obs_q.size();
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            gap  = stop ? $urandom_range(0, 20) : $urandom_range(4, 20);
            send_frame(d, stop, par);
            bus.rx_in = 1'b1;
            repeat (gap) @(negedge clk);
            e.d  = d;
            e.fe = ~stop;
            e.pe = exp_pe(d, par);
            exp_q.push_back(e);
            last_data = d;
        end
        repeat (40) @(negedge clk);
        total++;
        if (obs_q.size() != n0 + exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d want %0d", obs_q.size() - n0, exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                total++;
                if ({obs_q[n0+k].d, obs_q[n0+k].fe, obs_q[n0+k].pe} !== {exp_q[k].d, exp_q[k].fe, exp_q[k].pe}) begin
                    bad++;
                    $display("FAIL rand_frame%0d: got %h/%b/%b want %h/%b/%b", k,
                             obs_q[n0+k].d, obs_q[n0+k].fe, obs_q[n0+k].pe,
                             exp_q[k].d, exp_q[k].fe, exp_q[k].pe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_abort();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
